// File: rtl/bt656_pkg.sv
// Shared definitions for the BT656 byte-stream sequencer: FSM states, sync
// words, XY flag positions and the default active line length.
package bt656_pkg;

    typedef enum logic [2:0] {
        SEARCH,
        SYNC1,
        SYNC2,
        SYNC3,
        BLANK,
        ACTIVE
    } state_t;

    localparam logic [7:0] SYNC_FF = 8'hFF;
    localparam logic [7:0] SYNC_00 = 8'h00;

    localparam int XY_F = 6;
    localparam int XY_V = 5;
    localparam int XY_H = 4;

    localparam int H_ACTIVE_DEF = 720;

    // One spare bit so the pixel counter can sit at H_ACTIVE without wrapping.
    localparam int X_W = 11;

endpackage

// File: rtl/bt656_vld_delay.sv
// Fixed-latency alignment pipe for the pixel strobe and its sideband; a
// depth of zero degenerates to a plain wire.
module bt656_vld_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data,
    output logic [W-1:0] delayed
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign delayed = data;
        end else begin : g_pipe
            logic [W-1:0] pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= data;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign delayed = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/bt656_ycbcr_seq.sv
// BT656 byte stream to YCbCr pixel sequencer feeding a colour-space converter.
// Optional BT656_FIELD_EN adds out_field and start-of-frame on both fields.
module bt656_ycbcr_seq
    import bt656_pkg::*;
#(
    parameter int CONV_LAT = 1,
    parameter int H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_en,
    output logic [7:0] conv_y,
    output logic [7:0] conv_cb,
    output logic [7:0] conv_cr,
    output logic       out_vld,
    output logic       out_sol,
    output logic       out_sof,
    output logic [9:0] out_x,
`ifdef BT656_FIELD_EN
    output logic       out_field,
`endif
    output logic       err,
    output state_t     state
);

    // Handshake: in_data is consumed on every rising edge where in_en=1 and is
    // ignored otherwise (no back-pressure). out_vld is a single-cycle pulse
    // marking the cycle the converter's RGB (and out_sol/out_sof/out_x) is valid.

    localparam logic [X_W-1:0] X_LIM = X_W'(H_ACTIVE);

    state_t         state_nxt;
    logic           sav;
    logic           eav;
    logic           pix;

    logic [1:0]     phase;
    logic [X_W-1:0] x;
    logic [7:0]     cb_q;
    logic [7:0]     y0_q;
    logic [7:0]     cr_q;
    logic           line_act;
    logic           prev_v;
    logic           sof_pend;
    logic           field_ok;

    logic           stb;
    logic           stb_sol;
    logic           stb_sof;
    logic [9:0]     stb_x;

    logic           pix_emit;
    logic [7:0]     pix_y;
    logic [7:0]     pix_cr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sav       = 1'b0;
        eav       = 1'b0;
        pix       = 1'b0;
        if (in_en) begin
            if (in_data == SYNC_FF) begin
                state_nxt = SYNC1;
            end else begin
                case (state)
                    SYNC1: state_nxt = (in_data == SYNC_00) ? SYNC2 : SEARCH;
                    SYNC2: state_nxt = (in_data == SYNC_00) ? SYNC3 : SEARCH;
                    SYNC3: begin
                        sav       = !in_data[XY_H];
                        eav       = in_data[XY_H];
                        state_nxt = (!in_data[XY_H] && !in_data[XY_V]) ? ACTIVE : BLANK;
                    end
                    ACTIVE:  pix = 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef BT656_FIELD_EN
    assign field_ok = 1'b1;
`else
    assign field_ok = !in_data[XY_F];
`endif

    // Cr byte emits the Y0 pixel; Y1 byte emits the Y1 pixel. Cb is shared.
    assign pix_emit = pix && phase[1];
    assign pix_y    = phase[0] ? in_data : y0_q;
    assign pix_cr   = phase[0] ? cr_q : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            x        <= '0;
            cb_q     <= '0;
            y0_q     <= '0;
            cr_q     <= '0;
            line_act <= 1'b0;
            prev_v   <= 1'b0;
            sof_pend <= 1'b0;
            conv_y   <= '0;
            conv_cb  <= '0;
            conv_cr  <= '0;
            stb      <= 1'b0;
            stb_sol  <= 1'b0;
            stb_sof  <= 1'b0;
            stb_x    <= '0;
            err      <= 1'b0;
        end else begin
            stb     <= 1'b0;
            stb_sol <= 1'b0;
            stb_sof <= 1'b0;

            if (sav) begin
                prev_v   <= in_data[XY_V];
                phase    <= '0;
                x        <= '0;
                line_act <= !in_data[XY_V];
                sof_pend <= !in_data[XY_V] && prev_v && field_ok;
            end

            // A short or misaligned line drops whatever pair was in flight.
            if (eav) begin
                prev_v   <= in_data[XY_V];
                phase    <= '0;
                line_act <= 1'b0;
                sof_pend <= 1'b0;
                if (line_act && (phase != 2'd0 || x != X_LIM)) begin
                    err <= 1'b1;
                end
            end

            if (pix) begin
                phase <= phase + 2'd1;
                case (phase)
                    2'd0:    cb_q <= in_data;
                    2'd1:    y0_q <= in_data;
                    2'd2:    cr_q <= in_data;
                    default: ;
                endcase
                if (pix_emit) begin
                    if (x < X_LIM) begin
                        conv_y   <= pix_y;
                        conv_cb  <= cb_q;
                        conv_cr  <= pix_cr;
                        stb      <= 1'b1;
                        stb_sol  <= (x == '0);
                        stb_sof  <= sof_pend;
                        sof_pend <= 1'b0;
                        stb_x    <= x[9:0];
                        x        <= x + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef BT656_FIELD_EN
    localparam int PW = 14;
    logic f_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_lat <= 1'b0;
        end else if (sav) begin
            f_lat <= in_data[XY_F];
        end
    end

    logic [PW-1:0] pay;
    logic [PW-1:0] pay_q;
    assign pay = {stb, stb_sol, stb_sof, stb_x, f_lat};
    assign {out_vld, out_sol, out_sof, out_x, out_field} = pay_q;
`else
    localparam int PW = 13;
    logic [PW-1:0] pay;
    logic [PW-1:0] pay_q;
    assign pay = {stb, stb_sol, stb_sof, stb_x};
    assign {out_vld, out_sol, out_sof, out_x} = pay_q;
`endif

    bt656_vld_delay #(
        .W     (PW),
        .DEPTH (CONV_LAT)
    ) u_vld_delay (
        .clk     (clk),
        .rst     (rst),
        .data    (pay),
        .delayed (pay_q)
    );

endmodule

// File: tb/tb_bt656_ycbcr_seq.sv
// Directed bench for bt656_ycbcr_seq: vector table for the basic pair plus
// hand-written multi-cycle sequences; pixels are checked against a queue.
module tb_bt656_ycbcr_seq;
    import bt656_pkg::*;

    localparam int LAT = 1;
    localparam int HA  = 720;
    localparam int EW  = 53;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_en;
    logic [7:0] conv_y;
    logic [7:0] conv_cb;
    logic [7:0] conv_cr;
    logic       out_vld;
    logic       out_sol;
    logic       out_sof;
    logic [9:0] out_x;
    logic       err;
    state_t     state;
    logic       field_w;

    bt656_ycbcr_seq #(
        .CONV_LAT (LAT),
        .H_ACTIVE (HA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_en     (in_en),
        .conv_y    (conv_y),
        .conv_cb   (conv_cb),
        .conv_cr   (conv_cr),
        .out_vld   (out_vld),
        .out_sol   (out_sol),
        .out_sof   (out_sof),
        .out_x     (out_x),
`ifdef BT656_FIELD_EN
        .out_field (field_w),
`endif
        .err       (err),
        .state     (state)
    );

`ifndef BT656_FIELD_EN
    assign field_w = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int vld_count = 0;
    int last_cyc = 0;
    logic cur_f = 1'b0;

    logic [EW-1:0] exp_q[$];
    logic [23:0]   conv_hist [8];

    typedef struct {
        logic [7:0] b;
        logic       pix;
        logic [9:0] x;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       sol;
        logic       sof;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        in_en   = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        cur_f = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_en    = 1'b1;
        last_cyc = cyc;
    endtask

    // Idle cycles carry FF to show that unqualified bytes are ignored.
    task automatic idle();
        @(negedge clk);
        in_en   = 1'b0;
        in_data = 8'hFF;
    endtask

    task automatic send_sync(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
        if (!xy[4]) cur_f = xy[6];
    endtask

    task automatic push_exp(input int c, input logic sol, input logic sof, input int x,
                            input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        logic f;
`ifdef BT656_FIELD_EN
        f = cur_f;
`else
        f = 1'b0;
`endif
        exp_q.push_back({16'(c + LAT + 1), sol, sof, f, 10'(x), y, cb, cr});
    endtask

    task automatic send_pair(input logic [7:0] cb, input logic [7:0] y0, input logic [7:0] cr,
                             input logic [7:0] y1, input int x0, input logic sof0);
        send(cb);
        send(y0);
        send(cr);
        if (x0 < HA) push_exp(last_cyc, x0 == 0, sof0, x0, y0, cb, cr);
        send(y1);
        if (x0 + 1 < HA) push_exp(last_cyc, 1'b0, 1'b0, x0 + 1, y1, cb, cr);
    endtask

    task automatic send_line(input int pairs, input logic sof0);
        for (int i = 0; i < pairs; i++) begin
            send_pair(8'h40 + 8'(i % 32), 8'h10 + 8'(i % 64), 8'h60 + 8'(i % 32),
                      8'h50 + 8'(i % 64), 2 * i, (i == 0) ? sof0 : 1'b0);
        end
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 4) @(negedge clk);
        check("missing_vld", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic apply_tbl(input logic gap);
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].b);
            if (tbl[i].pix)
                push_exp(last_cyc, tbl[i].sol, tbl[i].sof, int'(tbl[i].x),
                         tbl[i].y, tbl[i].cb, tbl[i].cr);
            if (gap) idle();
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic pix, input logic [9:0] x,
                                input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                                input logic sol, input logic sof);
        vec_t v;
        v.b = b; v.pix = pix; v.x = x; v.y = y; v.cb = cb; v.cr = cr; v.sol = sol; v.sof = sof;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        conv_hist[cyc[2:0]] = {conv_y, conv_cb, conv_cr};
        if (out_vld === 1'b1) begin
            vld_count++;
            checks++;
            got = {16'(cyc), out_sol, out_sof, field_w, out_x, conv_hist[3'(cyc - LAT)]};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: got %0h, expected no pixel (cycle %0d)", got, cyc);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL pixel: got %0h, expected %0h (cycle %0d)", got, want, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n0;
        rst     = 1'b1;
        in_en   = 1'b0;
        in_data = 8'h00;

        tbl[0] = mk(8'hFF, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(8'h00, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(8'h00, 0, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(8'h80, 0, 0, 0, 0, 0, 0, 0);
        tbl[4] = mk(8'h80, 0, 0, 0, 0, 0, 0, 0);
        tbl[5] = mk(8'h10, 0, 0, 0, 0, 0, 0, 0);
        tbl[6] = mk(8'h90, 1, 10'd0, 8'h10, 8'h80, 8'h90, 1, 0);
        tbl[7] = mk(8'h20, 1, 10'd1, 8'h20, 8'h80, 8'h90, 0, 0);

        do_reset();
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_sol", 32'(out_sol), 32'd0);
        check("rst_sof", 32'(out_sof), 32'd0);
        check("rst_x", 32'(out_x), 32'd0);
        check("rst_conv", {8'h00, conv_y, conv_cb, conv_cr}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'(SEARCH));

        // Basic SAV + one pair, in_en held high.
        apply_tbl(1'b0);
        drain();
        check("basic_err", 32'(err), 32'd0);
        check("basic_state", 32'(state), 32'(ACTIVE));

        // Same bytes with in_en toggling every cycle.
        do_reset();
        apply_tbl(1'b1);
        drain();
        check("gap_err", 32'(err), 32'd0);

        // Start of frame after a V=1 line; sol on x=0 of each line.
        do_reset();
        send_sync(8'hAB);
        send_sync(8'h80);
        send_line(2, 1'b1);
        send_sync(8'h80);
        send_line(1, 1'b0);
        drain();
        // F=1 field: sof only when both fields are enabled.
        send_sync(8'hEB);
        send_sync(8'hC7);
`ifdef BT656_FIELD_EN
        send_line(1, 1'b1);
`else
        send_line(1, 1'b0);
`endif
        drain();
        check("sof_err", 32'(err), 32'd0);

        // Exactly H_ACTIVE pixels then EAV: clean line.
        do_reset();
        send_sync(8'h80);
        n0 = vld_count;
        send_line(HA / 2, 1'b0);
        send_sync(8'h9D);
        drain();
        check("full_line_count", 32'(vld_count - n0), 32'(HA));
        check("full_line_err", 32'(err), 32'd0);

        // 721 pairs: everything past x=719 is dropped and flagged.
        do_reset();
        send_sync(8'h80);
        n0 = vld_count;
        send_line(721, 1'b0);
        send_sync(8'h9D);
        drain();
        check("overflow_count", 32'(vld_count - n0), 32'(HA));
        check("overflow_err", 32'(err), 32'd1);

        // EAV after Cb,Y0,Cr: Y0 was already emitted on Cr, Y1 never appears.
        do_reset();
        send_sync(8'h80);
        send_line(2, 1'b0);
        send(8'h41);
        send(8'h22);
        send(8'h63);
        push_exp(last_cyc, 1'b0, 1'b0, 4, 8'h22, 8'h41, 8'h63);
        idle();
        check("partial_err_before", 32'(err), 32'd0);
        send_sync(8'h9D);
        drain();
        check("partial_err", 32'(err), 32'd1);
        check("partial_state", 32'(state), 32'(BLANK));

        // Reset mid-line clears err and silences output until the next SAV.
        send_sync(8'h80);
        send_line(1, 1'b0);
        send(8'h44);
        send(8'h33);
        drain();
        do_reset();
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_state", 32'(state), 32'(SEARCH));
        n0 = vld_count;
        send(8'h55);
        send(8'h66);
        for (int i = 0; i < 3; i++) begin
            send(8'h40); send(8'h11); send(8'h60); send(8'h12);
        end
        idle();
        repeat (LAT + 4) @(negedge clk);
        check("midrst_silent", 32'(vld_count - n0), 32'd0);
        send_sync(8'h80);
        send_line(1, 1'b0);
        drain();
        check("midrst_resume", 32'(vld_count - n0), 32'd2);
        check("midrst_err_end", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
